sd_seq_ctrl: RTL and testbench
==============================

# sd_seq_ctrl

Wishbone-programmable stimulus sequencer and result collector for the `iiitb_sd_fsm` sequence detector inside `user_project_wrapper`. Software loads a bit pattern and length, then starts a run. The block serialises the pattern LSB-first into the detector's `sequence_in` and counts cycles in which `detector_out` is high. It reports completion through a status register and `user_irq[0]`, and can repeat runs continuously.

## Interface
- `BASE_ADR`, default 32'h3000_0000: Wishbone base address; block decodes `wbs_adr_i[31:5] == BASE_ADR[31:5]`.
- `DET_LAT`, default 2: drain cycles after the last bit during which `det_i` is still counted (covers detector latency).
- `clock` in 1: single clock (`wb_clk_i`).
- `reset` in 1: synchronous, active-high (`wb_rst_i`).
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i` in 1 each: Wishbone request.
- `wbs_sel_i` in 4: byte enables.
- `wbs_adr_i` in 32: byte address.
- `wbs_dat_i` in 32: write data.
- `wbs_ack_o` out 1: one-cycle acknowledge.
- `wbs_dat_o` out 32: read data, valid with ack, 0 otherwise.
- `seq_bit_o` out 1: serial bit to detector `sequence_in`.
- `det_i` in 1: detector `detector_out`.
- `irq_o` out 1: level interrupt to `user_irq[0]`.

## Operation
- Register map (word offsets):
  - 0x00 CTRL [0] start (write-1 pulse, reads 0), [1] continuous, [2] abort (write-1 pulse, reads 0), [3] irq_en.
  - 0x04 PATTERN[31:0].
  - 0x08 LEN[5:0]: values 1..32; 0 and values >32 behave as 32.
  - 0x0C STATUS [0] busy (RO), [1] done (sticky, write-1-to-clear), [2] overflow (count saturated, W1C).
  - 0x10 COUNT[15:0] (RO).
  - Other offsets read 0; writes to them are ignored.
- Writes honour `wbs_sel_i` per byte on all RW registers.
- FSM states: IDLE, SHIFT, DRAIN, DONE.
  - IDLE: start → load shift register ← PATTERN, bit counter ← LEN, COUNT ← 0, overflow ← 0, done ← 0; go to SHIFT.
  - SHIFT: `seq_bit_o` = shreg[0]; shift right each cycle; decrement counter; after the last bit go to DRAIN.
  - DRAIN: `seq_bit_o` = 0 for exactly `DET_LAT` cycles, then go to DONE.
  - DONE (1 cycle): done ← 1. If continuous=1, reload as on start except COUNT, which keeps accumulating, and go to SHIFT. Otherwise go to IDLE.
- COUNT increments on every cycle in SHIFT or DRAIN with `det_i`=1. It saturates at 16'hFFFF; further hits set overflow.
- busy = (state != IDLE).
- irq_o = done & irq_en.
- Start while busy is ignored.
- Abort from any state: IDLE next cycle, `seq_bit_o`=0, done unchanged, COUNT retained. Abort and start in the same write: abort wins.
- Clearing continuous mid-run: the current run finishes, then the FSM returns to IDLE.
- Reset mid-run: everything returns to reset values on the next edge. No partial run resumes.

## Timing
- Reset values: `wbs_ack_o`=0, `wbs_dat_o`=0, `seq_bit_o`=0, `irq_o`=0, all registers 0, state IDLE.
- Ack: request sampled at edge E with `stb&cyc&~ack` and address hit → ack=1 for the cycle after E; writes take effect at E.
  - Max one transaction every 2 cycles.
  - Requests that miss the address decode are never acked.
- Start written at edge E: state=SHIFT after E+1; bit0 on `seq_bit_o` during cycle E+1..E+2; bit k during cycle E+1+k.
- Single run total: LEN shift cycles + DET_LAT drain cycles + 1 DONE cycle. done and irq visible the cycle after DONE.
- Continuous: no gap bit between runs beyond DRAIN+DONE.
- A W1C of done in the same cycle DONE sets it: set wins.

## Structure
- Package `sd_seq_ctrl_pkg`:
  - register offsets;
  - CTRL/STATUS bit-position constants;
  - FSM state enum;
  - COUNT width (16).
- Sub-module `sd_seq_ctrl_regs`: Wishbone decode, ack, byte-enable writes, read mux, start/abort pulse generation.
- FSM, shift register, bit counter and hit counter stay in the top.

## Test plan
- Reset → all outputs 0; reads of 0x00–0x10 return 0; bogus offset 0x14 reads 0.
- PATTERN=0x0000000D, LEN=4, start → `seq_bit_o` = 1,0,1,1 in cycles E+1..E+4. Then done=1 and busy=0 at E+4+DET_LAT+2; with irq_en=1, irq_o=1.
- Detector model (overlapping "1011"), PATTERN=0x0000006D (LSB-first 1011011), LEN=7 → COUNT=2. W1C of done drops irq_o next cycle.
- LEN=0, PATTERN=0xFFFFFFFF, det_i tied 1 → 32+DET_LAT hits, COUNT=34.
  - Continuous run to 0xFFFF, then one more hit → COUNT=0xFFFF, overflow=1.
- Start during SHIFT ignored (bit stream unchanged). Abort at bit 3 → IDLE next cycle, `seq_bit_o`=0, done=0.
- Reset asserted mid-SHIFT → next cycle state IDLE, COUNT=0, `seq_bit_o`=0, no ack pending.

Source files
------------

// File: rtl/sd_seq_ctrl_pkg.sv
// sd_seq_ctrl_pkg: register map, bit positions, FSM states and helpers for the sequence-detector stimulus controller
package sd_seq_ctrl_pkg;
    localparam logic [2:0] OFS_CTRL    = 3'd0;
    localparam logic [2:0] OFS_PATTERN = 3'd1;
    localparam logic [2:0] OFS_LEN     = 3'd2;
    localparam logic [2:0] OFS_STATUS  = 3'd3;
    localparam logic [2:0] OFS_COUNT   = 3'd4;
    localparam int CTRL_START = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_ABORT = 2;
    localparam int CTRL_IRQEN = 3;
    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_OVF  = 2;
    localparam int CNT_W = 16;
    typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, DONE} state_t;
    // LEN of 0 or above 32 runs the full 32-bit pattern
    function automatic logic [7:0] eff_len(input logic [5:0] l);
        return (l == 6'd0 || l > 6'd32) ? 8'd32 : {2'b00, l};
    endfunction
endpackage

// File: rtl/sd_seq_ctrl_regs.sv
// sd_seq_ctrl_regs: Wishbone slave with byte-enable register writes, read mux and start/abort pulses
module sd_seq_ctrl_regs
    import sd_seq_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wbs_stb_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    input  logic             busy,
    input  logic             done,
    input  logic             ovf,
    input  logic [CNT_W-1:0] count,
    output logic             start_p,
    output logic             abort_p,
    output logic             cont,
    output logic             irq_en,
    output logic [31:0]      pattern,
    output logic [5:0]       len,
    output logic             done_clr,
    output logic             ovf_clr
);
    logic req, wr, wr_ctrl, unused_adr;
    logic [2:0] ofs;
    logic [31:0] rdata;
    assign unused_adr = ^wbs_adr_i[1:0];
    assign req = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o & (wbs_adr_i[31:5] == BASE_ADR[31:5]);
    assign wr = req & wbs_we_i;
    assign ofs = wbs_adr_i[4:2];
    assign wr_ctrl = wr & (ofs == OFS_CTRL) & wbs_sel_i[0];
    // W1C strobes act on the request edge so software sees the clear with the ack
    assign done_clr = wr & (ofs == OFS_STATUS) & wbs_sel_i[0] & wbs_dat_i[ST_DONE];
    assign ovf_clr = wr & (ofs == OFS_STATUS) & wbs_sel_i[0] & wbs_dat_i[ST_OVF];
    always_comb begin
        rdata = '0;
        rdata = ofs == OFS_CTRL    ? 32'({irq_en, 1'b0, cont, 1'b0}) :
                ofs == OFS_PATTERN ? pattern :
                ofs == OFS_LEN     ? 32'(len) :
                ofs == OFS_STATUS  ? 32'({ovf, done, busy}) :
                ofs == OFS_COUNT   ? 32'(count) : 32'd0;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            start_p <= 1'b0;
            abort_p <= 1'b0;
            cont <= 1'b0;
            irq_en <= 1'b0;
            pattern <= '0;
            len <= '0;
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= (req & ~wbs_we_i) ? rdata : '0;
            start_p <= wr_ctrl & wbs_dat_i[CTRL_START] & ~wbs_dat_i[CTRL_ABORT];
            abort_p <= wr_ctrl & wbs_dat_i[CTRL_ABORT];
            if (wr_ctrl) begin
                cont <= wbs_dat_i[CTRL_CONT];
                irq_en <= wbs_dat_i[CTRL_IRQEN];
            end
            for (int i = 0; i < 4; i++)
                if (wr && ofs == OFS_PATTERN && wbs_sel_i[i]) pattern[8*i +: 8] <= wbs_dat_i[8*i +: 8];
            if (wr && ofs == OFS_LEN && wbs_sel_i[0]) len <= wbs_dat_i[5:0];
        end
    end
endmodule

// File: rtl/sd_seq_ctrl.sv
// sd_seq_ctrl: serialises a programmed pattern into the sequence detector and counts detector hits
module sd_seq_ctrl
    import sd_seq_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADR = 32'h3000_0000,
    parameter int          DET_LAT  = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        seq_bit_o,
    input  logic        det_i,
    output logic        irq_o
);
    state_t state;
    logic [31:0] shreg, pattern;
    logic [7:0] cnt;
    logic [5:0] len;
    logic [CNT_W-1:0] count;
    logic done, ovf, seq_bit, start_p, abort_p, cont, irq_en, done_clr, ovf_clr, hit, load;
    sd_seq_ctrl_regs #(.BASE_ADR(BASE_ADR)) u_regs (
        .clock(clock), .reset(reset),
        .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i), .wbs_sel_i(wbs_sel_i),
        .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .busy(state != IDLE), .done(done), .ovf(ovf), .count(count),
        .start_p(start_p), .abort_p(abort_p), .cont(cont), .irq_en(irq_en),
        .pattern(pattern), .len(len), .done_clr(done_clr), .ovf_clr(ovf_clr)
    );
    assign hit = (state == SHIFT || state == DRAIN) & det_i;
    // a fresh start and a continuous re-arm share the same pattern load
    assign load = (state == IDLE & start_p) | (state == DONE & cont);
    assign seq_bit_o = seq_bit;
    assign irq_o = done & irq_en;
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            shreg <= '0;
            cnt <= '0;
            count <= '0;
            done <= 1'b0;
            ovf <= 1'b0;
            seq_bit <= 1'b0;
        end else begin
            if (done_clr) done <= 1'b0;
            if (ovf_clr) ovf <= 1'b0;
            if (hit) begin
                if (&count) ovf <= 1'b1;
                else count <= count + 1'b1;
            end
            if (abort_p) begin
                state <= IDLE;
                seq_bit <= 1'b0;
            end else if (load) begin
                state <= SHIFT;
                seq_bit <= pattern[0];
                shreg <= {1'b0, pattern[31:1]};
                cnt <= eff_len(len);
                if (state == IDLE) begin
                    count <= '0;
                    ovf <= 1'b0;
                    done <= 1'b0;
                end else begin
                    done <= 1'b1;
                end
            end else begin
                case (state)
                    SHIFT: begin
                        if (cnt == 8'd1) begin
                            seq_bit <= 1'b0;
                            state <= (DET_LAT == 0) ? DONE : DRAIN;
                            cnt <= 8'(DET_LAT);
                        end else begin
                            seq_bit <= shreg[0];
                            shreg <= shreg >> 1;
                            cnt <= cnt - 8'd1;
                        end
                    end
                    DRAIN: begin
                        if (cnt == 8'd1) state <= DONE;
                        else cnt <= cnt - 8'd1;
                    end
                    DONE: begin
                        done <= 1'b1;
                        state <= IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sd_seq_ctrl.sv
// tb_sd_seq_ctrl: register vector table plus hand sequences, Wishbone reads checked through a scoreboard queue
module tb_sd_seq_ctrl;
    localparam logic [31:0] BASE = 32'h3000_0000;
    logic clk = 1'b0, reset = 1'b1;
    logic stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0] sel = '0;
    logic [31:0] adr = '0, dat = '0;
    logic ack, seq_bit, irq, det_i, det_tie = 1'b0;
    logic [31:0] dat_o;
    logic [3:0] hist = '0;
    int tests = 0, fails = 0;

    typedef struct { logic chk; logic [31:0] exp; string name; } sb_t;
    typedef struct { logic we; logic [7:0] ofs; logic [31:0] dat; logic [3:0] sel; logic [31:0] exp; string name; } vec_t;
    sb_t sbq[$];
    vec_t vt[$];

    sd_seq_ctrl dut (
        .clock(clk), .reset(reset), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .seq_bit_o(seq_bit), .det_i(det_i), .irq_o(irq)
    );

    always #5 clk = ~clk;
    // overlapping "1011" detector with one cycle of output latency
    always @(posedge clk) hist <= {hist[2:0], seq_bit};
    assign det_i = det_tie | (hist == 4'b1011);

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        sb_t s;
        if (ack) begin
            if (sbq.size() == 0) check("ack_without_request", {31'd0, ack}, 32'd0);
            else begin
                s = sbq.pop_front();
                if (s.chk) check(s.name, dat_o, s.exp);
            end
        end
    end

    task automatic xfer(input logic w, input logic [7:0] o, input logic [31:0] d, input logic [3:0] s,
                        input logic chk, input logic [31:0] exp, input string n, output logic [31:0] rd);
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = w; adr = BASE + 32'(o); dat = d; sel = s;
        sbq.push_back('{chk, exp, n});
        @(negedge clk);
        rd = dat_o;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [7:0] o, input logic [31:0] d);
        logic [31:0] x;
        xfer(1'b1, o, d, 4'hF, 1'b0, '0, "wr", x);
    endtask

    task automatic rd_chk(input logic [7:0] o, input logic [31:0] exp, input string n);
        logic [31:0] x;
        xfer(1'b0, o, '0, 4'hF, 1'b1, exp, n, x);
    endtask

    task automatic rd_raw(input logic [7:0] o, output logic [31:0] v);
        xfer(1'b0, o, '0, 4'hF, 1'b0, '0, "raw", v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] v, pat;
        logic idle_seen;
        vt = '{
            '{1'b0, 8'h00, 32'h0, 4'hF, 32'h0, "rst_ctrl"},
            '{1'b0, 8'h04, 32'h0, 4'hF, 32'h0, "rst_pattern"},
            '{1'b0, 8'h08, 32'h0, 4'hF, 32'h0, "rst_len"},
            '{1'b0, 8'h0C, 32'h0, 4'hF, 32'h0, "rst_status"},
            '{1'b0, 8'h10, 32'h0, 4'hF, 32'h0, "rst_count"},
            '{1'b0, 8'h14, 32'h0, 4'hF, 32'h0, "bogus_rd"},
            '{1'b1, 8'h04, 32'hA5A5A5A5, 4'hF, 32'h0, ""},
            '{1'b0, 8'h04, 32'h0, 4'hF, 32'hA5A5A5A5, "pattern_full"},
            '{1'b1, 8'h04, 32'h11223344, 4'h5, 32'h0, ""},
            '{1'b0, 8'h04, 32'h0, 4'hF, 32'hA522A544, "pattern_sel"},
            '{1'b1, 8'h08, 32'h00000127, 4'h1, 32'h0, ""},
            '{1'b0, 8'h08, 32'h0, 4'hF, 32'h00000027, "len_6bit"},
            '{1'b1, 8'h08, 32'h00000005, 4'h2, 32'h0, ""},
            '{1'b0, 8'h08, 32'h0, 4'hF, 32'h00000027, "len_sel_off"},
            '{1'b1, 8'h00, 32'h0000000A, 4'hF, 32'h0, ""},
            '{1'b0, 8'h00, 32'h0, 4'hF, 32'h0000000A, "ctrl_rw"},
            '{1'b1, 8'h00, 32'h00000000, 4'hF, 32'h0, ""},
            '{1'b0, 8'h00, 32'h0, 4'hF, 32'h00000000, "ctrl_clear"},
            '{1'b1, 8'h14, 32'hFFFFFFFF, 4'hF, 32'h0, ""},
            '{1'b0, 8'h14, 32'h0, 4'hF, 32'h0, "bogus_wr"},
            '{1'b1, 8'h10, 32'h0000FFFF, 4'hF, 32'h0, ""},
            '{1'b0, 8'h10, 32'h0, 4'hF, 32'h0, "count_ro"},
            '{1'b1, 8'h0C, 32'h00000007, 4'hF, 32'h0, ""},
            '{1'b0, 8'h0C, 32'h0, 4'hF, 32'h0, "status_w1c_idle"}
        };
        repeat (3) @(negedge clk);
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_dat", dat_o, 32'd0);
        check("rst_seq", {31'd0, seq_bit}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        reset = 1'b0;
        foreach (vt[i]) xfer(vt[i].we, vt[i].ofs, vt[i].dat, vt[i].sel, ~vt[i].we, vt[i].exp, vt[i].name, v);

        // 4-bit run: bit stream, then done/irq timing
        wr(8'h04, 32'h0000000D);
        wr(8'h08, 32'd4);
        wr(8'h00, 32'h8);
        wr(8'h00, 32'h9);
        pat = 32'h0000000D;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("run4_bit%0d", k), {31'd0, seq_bit}, {31'd0, pat[k]});
        end
        repeat (3) @(negedge clk);
        check("run4_irq_early", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check("run4_irq", {31'd0, irq}, 32'd1);
        rd_chk(8'h0C, 32'h2, "run4_status");

        // detector model: overlapping 1011 found twice
        wr(8'h04, 32'h0000006D);
        wr(8'h08, 32'd7);
        wr(8'h00, 32'h9);
        repeat (15) @(negedge clk);
        rd_chk(8'h10, 32'd2, "det_count");
        check("det_irq", {31'd0, irq}, 32'd1);
        wr(8'h0C, 32'h2);
        check("w1c_irq_drop", {31'd0, irq}, 32'd0);
        rd_chk(8'h0C, 32'h0, "w1c_status");

        // LEN=0 behaves as 32, plus drain hits
        det_tie = 1'b1;
        wr(8'h04, 32'hFFFFFFFF);
        wr(8'h08, 32'd0);
        wr(8'h00, 32'h1);
        repeat (40) @(negedge clk);
        rd_chk(8'h10, 32'd34, "len0_count");

        // continuous runs until the counter saturates
        wr(8'h00, 32'h3);
        repeat (67700) @(negedge clk);
        wr(8'h00, 32'h0);
        idle_seen = 1'b0;
        v = '0;
        for (int n = 0; n < 100 && !idle_seen; n++) begin
            rd_raw(8'h0C, v);
            idle_seen = ~v[0];
        end
        if (!idle_seen) check("cont_stop_timeout", {31'd0, v[0]}, 32'd0);
        rd_chk(8'h10, 32'h0000FFFF, "sat_count");
        rd_chk(8'h0C, 32'h6, "sat_status");
        wr(8'h0C, 32'h4);
        rd_chk(8'h0C, 32'h2, "ovf_w1c");

        // restart during SHIFT ignored, abort after bit 3
        pat = 32'h00000013;
        wr(8'h04, pat);
        wr(8'h08, 32'd8);
        wr(8'h00, 32'h1);
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    check($sformatf("abort_bit%0d", k), {31'd0, seq_bit}, {31'd0, pat[k]});
                end
                @(negedge clk);
                check("abort_seq0", {31'd0, seq_bit}, 32'd0);
            end
            begin
                wr(8'h00, 32'h1);
                wr(8'h00, 32'h4);
            end
        join
        rd_chk(8'h0C, 32'h0, "abort_status");
        rd_chk(8'h10, 32'd4, "abort_count");
        wr(8'h00, 32'h5);
        repeat (2) @(negedge clk);
        rd_chk(8'h0C, 32'h0, "abort_wins");

        // reset mid-SHIFT with a read request in flight
        wr(8'h00, 32'h1);
        repeat (2) @(negedge clk);
        reset = 1'b1; stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE + 32'h10;
        @(negedge clk);
        check("midrst_ack", {31'd0, ack}, 32'd0);
        check("midrst_seq", {31'd0, seq_bit}, 32'd0);
        reset = 1'b0; stb = 1'b0; cyc = 1'b0;
        @(negedge clk);
        rd_chk(8'h10, 32'd0, "midrst_count");
        rd_chk(8'h0C, 32'd0, "midrst_status");
        rd_chk(8'h04, 32'd0, "midrst_pattern");

        // address outside the decoded window is never acked
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; adr = BASE + 32'h20;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("miss_no_ack", {31'd0, ack}, 32'd0);
        end
        stb = 1'b0; cyc = 1'b0;
        repeat (2) @(negedge clk);
        check("sb_empty", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
